// File: rtl/bnn_pkg.sv
// Shared constants and FSM encoding for the BNN conv-layer front end.
package bnn_pkg;

    localparam int DW    = 8;
    localparam int NI_L1 = 28;
    localparam int NI_L2 = 12;
    localparam int K     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One raster line of delay: a DEPTH-deep shift register that advances only
// when enabled. Contents are deliberately not reset; consumers mask stale
// data with their own valid flags.
module line_delay #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Shift one position per enabled beat; the tail is the pixel DEPTH beats ago.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window.sv
// Raster-to-column window generator: buffers K-1 previous rows and emits a
// K-pixel vertical column per accepted pixel, oldest row in the top byte.
//
// state   | meaning
// IDLE    | waiting for start; row/col held at 0
// RUN     | accepting pixels of the current frame
// DONE    | frame complete; waiting for start to drop
module conv_window #(
    parameter int K  = bnn_pkg::K,
    parameter int Ni = bnn_pkg::NI_L1,
    parameter int DW = bnn_pkg::DW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_din_valid,
    input  logic [DW-1:0]   i_din,
    output logic [DW*K-1:0] o_taps,
    output logic            o_tvalid,
    output logic            o_wvalid,
    output logic            o_done,
    output logic            o_busy
);
    import bnn_pkg::*;

    localparam int            CW   = cnt_width(Ni);
    localparam logic [CW-1:0] LAST = CW'(Ni - 1);
    localparam logic [CW-1:0] KM1  = CW'(K - 1);

    state_t            r_state;
    logic [CW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [DW*K-1:0]   r_taps;
    logic              r_tvalid;
    logic              r_wvalid;
    logic              r_done;
    logic              r_busy;

    logic              w_accept;
    // Byte 0 is the incoming pixel; byte i+1 is the output of delay line i.
    logic [DW*K-1:0]   w_chain;

    // Dropping start on the same edge as a beat aborts instead of accepting.
    assign w_accept       = (r_state == ST_RUN) && i_start && i_din_valid;
    assign w_chain[DW-1:0] = i_din;

    for (genvar g = 0; g < K - 1; g++) begin : g_line
        line_delay #(
            .DEPTH (Ni),
            .WIDTH (DW)
        ) u_line (
            .i_clk  (i_clk),
            .i_en   (w_accept),
            .i_din  (w_chain[g*DW +: DW]),
            .o_dout (w_chain[(g+1)*DW +: DW])
        );
    end

    // Frame FSM, raster counters and the registered column/flag outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_row    <= '0;
            r_col    <= '0;
            r_taps   <= '0;
            r_tvalid <= 1'b0;
            r_wvalid <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            r_wvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_row <= '0;
                    r_col <= '0;
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!i_start) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end else if (i_din_valid) begin
                        r_taps   <= w_chain;
                        r_tvalid <= (r_row >= KM1);
                        r_wvalid <= (r_row >= KM1) && (r_col >= KM1);
                        if (r_col == LAST) begin
                            r_col <= '0;
                            if (r_row == LAST) begin
                                r_row   <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_taps   = r_taps;
    assign o_tvalid = r_tvalid;
    assign o_wvalid = r_wvalid;
    assign o_done   = r_done;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_conv_window.sv
// Self-checking bench for conv_window: a frame-level reference model checks
// every cycle, plus table vectors and scenario-level counts.
module tb_conv_window;

    localparam int K   = 5;
    localparam int DW  = 8;
    localparam int NI1 = 28;
    localparam int NI2 = 12;
    localparam int TW  = K * DW;
    localparam int MAXP = NI1 * NI1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start1, dv1, start2, dv2;
    logic [DW-1:0] din1, din2;
    logic [TW-1:0] taps1, taps2;
    logic          tv1, wv1, dn1, bz1;
    logic          tv2, wv2, dn2, bz2;

    conv_window #(.K(K), .Ni(NI1), .DW(DW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_din_valid(dv1), .i_din(din1),
        .o_taps(taps1), .o_tvalid(tv1), .o_wvalid(wv1), .o_done(dn1), .o_busy(bz1)
    );

    conv_window #(.K(K), .Ni(NI2), .DW(DW)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_din_valid(dv2), .i_din(din2),
        .o_taps(taps2), .o_tvalid(tv2), .o_wvalid(wv2), .o_done(dn2), .o_busy(bz2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase, pixel index in frame, the frame pixels themselves.
    int            m_phase;   // 0 idle, 1 running, 2 finished
    int            m_n;
    logic [DW-1:0] m_frame [MAXP];
    logic [TW-1:0] m_taps;
    bit            m_known;
    bit            e_tv, e_wv, e_dn, e_bz;

    int            cnt_tv, cnt_wv, cnt_dn;
    logic [TW-1:0] tvq [$];
    logic [TW-1:0] ref_q [$];
    logic [TW-1:0] cap_taps [2][MAXP];
    bit            cap_tv [2][MAXP];
    bit            cap_wv [2][MAXP];
    bit            cap_dn [2][MAXP];

    typedef struct {
        int            sel;
        int            idx;
        bit            chk_taps;
        logic [TW-1:0] taps;
        bit            tv;
        bit            wv;
        bit            dn;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_tv = 0;
        cnt_wv = 0;
        cnt_dn = 0;
        tvq.delete();
    endtask

    // One clock: drive inputs, predict from the frame model, compare after the edge.
    task automatic cyc(input int sel, input bit r, input bit st, input bit dv, input logic [DW-1:0] d);
        int            ni = (sel == 0) ? NI1 : NI2;
        int            acc = -1;
        logic [TW-1:0] a_taps;
        bit            a_tv, a_wv, a_dn, a_bz;
        rst    = r;
        start1 = (sel == 0) && st;
        dv1    = (sel == 0) && dv;
        din1   = d;
        start2 = (sel == 1) && st;
        dv2    = (sel == 1) && dv;
        din2   = d;
        e_tv = 0; e_wv = 0; e_dn = 0;
        if (r) begin
            m_phase = 0; m_n = 0; m_taps = '0; m_known = 1;
        end else begin
            case (m_phase)
                0: begin
                    m_n = 0;
                    if (st) m_phase = 1;
                end
                1: begin
                    if (!st) begin
                        m_phase = 0; m_n = 0;
                    end else if (dv) begin
                        int row = m_n / ni;
                        int col = m_n % ni;
                        m_frame[m_n] = d;
                        acc = m_n;
                        if (row >= K - 1) begin
                            for (int i = 0; i < K; i++)
                                m_taps[i*DW +: DW] = m_frame[(row - i) * ni + col];
                            m_known = 1;
                            e_tv = 1;
                            e_wv = (col >= K - 1);
                        end else begin
                            m_known = 0;
                        end
                        m_n++;
                        if (m_n == ni * ni) begin
                            e_dn = 1;
                            m_phase = 2;
                        end
                    end
                end
                default: if (!st) m_phase = 0;
            endcase
        end
        e_bz = (m_phase == 1);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            a_taps = taps1; a_tv = tv1; a_wv = wv1; a_dn = dn1; a_bz = bz1;
        end else begin
            a_taps = taps2; a_tv = tv2; a_wv = wv2; a_dn = dn2; a_bz = bz2;
        end
        chk("tvalid", 64'(a_tv), 64'(e_tv));
        chk("wvalid", 64'(a_wv), 64'(e_wv));
        chk("done", 64'(a_dn), 64'(e_dn));
        chk("busy", 64'(a_bz), 64'(e_bz));
        if (m_known) chk("taps", 64'(a_taps), 64'(m_taps));
        if (a_tv) begin
            cnt_tv++;
            tvq.push_back(a_taps);
        end
        if (a_wv) cnt_wv++;
        if (a_dn) cnt_dn++;
        if (acc >= 0) begin
            cap_taps[sel][acc] = a_taps;
            cap_tv[sel][acc]   = a_tv;
            cap_wv[sel][acc]   = a_wv;
            cap_dn[sel][acc]   = a_dn;
        end
    endtask

    // Full frame. mode 0 continuous, 1 alternate-cycle valid, 2 random gaps.
    task automatic run_frame(input int sel, input int mode, input bit rnd);
        int ni = (sel == 0) ? NI1 : NI2;
        int n = 0;
        int c = 0;
        cyc(sel, 0, 1, 0, 8'h00);
        while (n < ni * ni) begin
            bit            dv;
            logic [DW-1:0] d;
            case (mode)
                0:       dv = 1;
                1:       dv = c[0];
                default: dv = ($urandom_range(0, 3) != 0);
            endcase
            c++;
            d = rnd ? 8'($urandom_range(0, 255)) : 8'(n);
            cyc(sel, 0, 1, dv, d);
            if (dv) n++;
        end
        cyc(sel, 0, 1, 1, 8'hAA);
        cyc(sel, 0, 0, 0, 8'h00);
        cyc(sel, 0, 0, 0, 8'h00);
    endtask

    task automatic apply_vectors(input int sel);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].sel == sel) begin
                chk($sformatf("vec%0d_tv", i), 64'(cap_tv[sel][vecs[i].idx]), 64'(vecs[i].tv));
                chk($sformatf("vec%0d_wv", i), 64'(cap_wv[sel][vecs[i].idx]), 64'(vecs[i].wv));
                chk($sformatf("vec%0d_dn", i), 64'(cap_dn[sel][vecs[i].idx]), 64'(vecs[i].dn));
                if (vecs[i].chk_taps)
                    chk($sformatf("vec%0d_taps", i), 64'(cap_taps[sel][vecs[i].idx]), 64'(vecs[i].taps));
            end
        end
    endtask

    task automatic cmp_ref(input string name);
        chk({name, "_len"}, 64'(tvq.size()), 64'(ref_q.size()));
        if (tvq.size() == ref_q.size())
            for (int i = 0; i < ref_q.size(); i++)
                chk(name, 64'(tvq[i]), 64'(ref_q[i]));
    endtask

    initial begin
        int first_tv;
        vecs[0] = '{0, 112, 1, 40'h001C385470, 1, 0, 0};
        vecs[1] = '{0, 111, 0, 40'h0,          0, 0, 0};
        vecs[2] = '{0, 115, 1, 40'h031F3B5773, 1, 0, 0};
        vecs[3] = '{0, 116, 1, 40'h04203C5874, 1, 1, 0};
        vecs[4] = '{0, 140, 1, 40'h1C3854708C, 1, 0, 0};
        vecs[5] = '{0, 783, 1, 40'h9FBBD7F30F, 1, 1, 1};
        vecs[6] = '{1, 48,  1, 40'h000C182430, 1, 0, 0};
        vecs[7] = '{1, 47,  0, 40'h0,          0, 0, 0};
        vecs[8] = '{1, 143, 1, 40'h5F6B77838F, 1, 1, 1};
        vecs[9] = '{1, 52,  1, 40'h04101C2834, 1, 1, 0};

        rst = 1; start1 = 0; dv1 = 0; din1 = 0; start2 = 0; dv2 = 0; din2 = 0;
        m_phase = 0; m_n = 0; m_taps = '0; m_known = 0;
        clear_counts();

        // Reset, with start and valid asserted to show reset priority.
        cyc(0, 1, 1, 1, 8'h55);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h11);

        // Continuous reference frame.
        clear_counts();
        run_frame(0, 0, 0);
        chk("l1_tvalid_count", 64'(cnt_tv), 64'd672);
        chk("l1_wvalid_count", 64'(cnt_wv), 64'd576);
        chk("l1_done_count", 64'(cnt_dn), 64'd1);
        ref_q = tvq;
        apply_vectors(0);
        first_tv = -1;
        for (int i = MAXP - 1; i >= 0; i--)
            if (cap_tv[0][i]) first_tv = i;
        chk("first_tvalid_pixel", 64'(first_tv), 64'd112);

        // Gapped input must reproduce the same column sequence.
        clear_counts();
        run_frame(0, 1, 0);
        cmp_ref("gap_col");
        chk("gap_done_count", 64'(cnt_dn), 64'd1);

        // Abort after pixel 300, then a clean frame.
        clear_counts();
        cyc(0, 0, 1, 0, 8'h00);
        for (int n = 0; n <= 300; n++) cyc(0, 0, 1, 1, 8'(n));
        cyc(0, 0, 0, 1, 8'(301));
        cyc(0, 0, 0, 0, 8'h00);
        chk("abort_done_count", 64'(cnt_dn), 64'd0);
        clear_counts();
        run_frame(0, 0, 0);
        cmp_ref("restart_col");
        chk("restart_done_count", 64'(cnt_dn), 64'd1);

        // Reset mid-frame with start held high.
        clear_counts();
        cyc(0, 0, 1, 0, 8'h00);
        for (int n = 0; n < 200; n++) cyc(0, 0, 1, 1, 8'(n));
        cyc(0, 1, 1, 1, 8'(200));
        chk("rst_mid_taps", 64'(taps1), 64'd0);
        clear_counts();
        run_frame(0, 0, 0);
        chk("post_rst_tvalid_count", 64'(cnt_tv), 64'd672);
        cmp_ref("post_rst_col");

        // Random data and gaps against the model.
        for (int f = 0; f < 3; f++) begin
            clear_counts();
            run_frame(0, 2, 1);
            chk("rnd_tvalid_count", 64'(cnt_tv), 64'd672);
            chk("rnd_done_count", 64'(cnt_dn), 64'd1);
        end

        // Random start drops, occasional reset, random valid and data.
        for (int c = 0; c < 3000; c++) begin
            bit st = ($urandom_range(0, 99) >= 2);
            bit r  = ($urandom_range(0, 999) < 3);
            bit dv = ($urandom_range(0, 3) != 0);
            cyc(0, r, st, dv, 8'($urandom_range(0, 255)));
        end
        cyc(0, 0, 0, 0, 8'h00);

        // Layer-2 instance; reset first so the model matches that DUT.
        cyc(1, 1, 0, 0, 8'h00);
        clear_counts();
        run_frame(1, 0, 0);
        chk("l2_tvalid_count", 64'(cnt_tv), 64'd96);
        chk("l2_wvalid_count", 64'(cnt_wv), 64'd64);
        chk("l2_done_count", 64'(cnt_dn), 64'd1);
        apply_vectors(1);
        clear_counts();
        run_frame(1, 2, 1);
        chk("l2_rnd_tvalid_count", 64'(cnt_tv), 64'd96);
        chk("l2_rnd_wvalid_count", 64'(cnt_wv), 64'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
